// File: rtl/shift_ctrl_arb_pkg.sv
// Shared op/state codes and helpers for the shift sequencer/arbiter.
package shift_ctrl_arb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SHOP_SRL = 2'b00,
        SHOP_SLL = 2'b01,
        SHOP_ROR = 2'b10,
        SHOP_ROL = 2'b11
    } shop_e;

    typedef enum logic [1:0] {
        SHST_IDLE  = 2'b00,
        SHST_PASS1 = 2'b01,
        SHST_PASS2 = 2'b10,
        SHST_DONE  = 2'b11
    } shst_e;

    function automatic logic is_rotate(input shop_e op);
        return (op == SHOP_ROR) || (op == SHOP_ROL);
    endfunction

    function automatic logic is_left(input shop_e op);
        return (op == SHOP_SLL) || (op == SHOP_ROL);
    endfunction

endpackage

// File: rtl/shift_ctrl_arb_rr_arb2.sv
// Two-way round-robin grant; priority flips to the other requester after every grant.
// Grant is combinational from req/en; only the priority bit is stored.
module shift_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt_id,
    output logic       gnt_valid
);

    logic prio;

    always_comb begin
        gnt_valid = en & (|req);
        gnt_id    = (req == 2'b11) ? prio : req[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (gnt_valid) begin
            prio <= ~gnt_id;
        end
    end

endmodule

// File: rtl/shift_ctrl_arb.sv
// Sequences one external 32-bit shifter for two requesters; rotates use two ORed passes.
// Result is registered and tagged with the owning requester.
module shift_ctrl_arb
    import shift_ctrl_arb_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic [1:0]        OP0,
    input  logic [1:0]        OP1,
    input  logic [DATA_W-1:0] DATA0,
    input  logic [DATA_W-1:0] DATA1,
    input  logic [DATA_W-1:0] SHAMT0,
    input  logic [DATA_W-1:0] SHAMT1,
    output logic              ACK0,
    output logic              ACK1,
    output logic [DATA_W-1:0] RESULT,
    output logic              RESULT_VALID,
    output logic              RESULT_ID,
    output logic [DATA_W-1:0] SH_D,
    output logic [DATA_W-1:0] SH_S,
    output logic              SH_LNR,
    input  logic [DATA_W-1:0] SH_Y
);

    shst_e             state_q, state_d;
    shop_e             op_q;
    logic [DATA_W-1:0] data_q, shamt_q, acc_q, acc_d, result_q;
    logic              id_q, result_id_q, result_vld_q;
    logic              gnt_id, gnt_valid;
    logic [5:0]        back_amt;

    shift_rr_arb2 u_arb (
        .clk       (CLK),
        .rst       (RST),
        .req       ({REQ1, REQ0}),
        .en        (state_q == SHST_IDLE),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    // Second rotate pass moves the wrapped bits the other way by 32 - n.
    assign back_amt = 6'd32 - {1'b0, shamt_q[4:0]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        SH_D    = '0;
        SH_S    = '0;
        SH_LNR  = 1'b0;
        case (state_q)
            SHST_IDLE: begin
                if (gnt_valid) state_d = SHST_PASS1;
            end
            SHST_PASS1: begin
                SH_D   = data_q;
                SH_S   = is_rotate(op_q) ? {27'b0, shamt_q[4:0]} : shamt_q;
                SH_LNR = is_left(op_q);
                acc_d  = SH_Y;
                state_d = (is_rotate(op_q) && (shamt_q[4:0] != 5'd0)) ? SHST_PASS2 : SHST_DONE;
            end
            SHST_PASS2: begin
                SH_D    = data_q;
                SH_S    = {26'b0, back_amt};
                SH_LNR  = ~is_left(op_q);
                acc_d   = acc_q | SH_Y;
                state_d = SHST_DONE;
            end
            SHST_DONE: begin
                state_d = SHST_IDLE;
            end
            default: state_d = SHST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= SHST_IDLE;
            op_q         <= SHOP_SRL;
            data_q       <= '0;
            shamt_q      <= '0;
            id_q         <= 1'b0;
            acc_q        <= '0;
            result_q     <= '0;
            result_id_q  <= 1'b0;
            result_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            result_vld_q <= (state_d == SHST_DONE);
            if (gnt_valid) begin
                id_q    <= gnt_id;
                op_q    <= gnt_id ? shop_e'(OP1) : shop_e'(OP0);
                data_q  <= gnt_id ? DATA1 : DATA0;
                shamt_q <= gnt_id ? SHAMT1 : SHAMT0;
            end
            // Result register only changes on entry to DONE so it holds between ops.
            if (state_d == SHST_DONE) begin
                result_q    <= acc_d;
                result_id_q <= id_q;
            end
        end
    end

    assign ACK0         = (state_q == SHST_PASS1) && !id_q;
    assign ACK1         = (state_q == SHST_PASS1) &&  id_q;
    assign RESULT       = result_q;
    assign RESULT_ID    = result_id_q;
    assign RESULT_VALID = result_vld_q;

endmodule

// File: tb/tb_shift_ctrl_arb.sv
// Directed bench for shift_ctrl_arb with a behavioural shifter and a transaction-level reference model.
module tb_shift_ctrl_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [1:0]  op0 = 2'd0, op1 = 2'd0;
    logic [31:0] data0 = '0, data1 = '0, shamt0 = '0, shamt1 = '0;
    logic        ack0, ack1, result_valid, result_id, sh_lnr;
    logic [31:0] result, sh_d, sh_s, sh_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_ctrl_arb dut (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .REQ1(req1), .OP0(op0), .OP1(op1),
        .DATA0(data0), .DATA1(data1), .SHAMT0(shamt0), .SHAMT1(shamt1),
        .ACK0(ack0), .ACK1(ack1),
        .RESULT(result), .RESULT_VALID(result_valid), .RESULT_ID(result_id),
        .SH_D(sh_d), .SH_S(sh_s), .SH_LNR(sh_lnr), .SH_Y(sh_y)
    );

    // Behavioural SHIFT32: amounts of 32 or more clear the word.
    assign sh_y = (sh_s >= 32) ? 32'h0 : (sh_lnr ? (sh_d << sh_s) : (sh_d >> sh_s));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] d, input logic [31:0] s);
        logic [63:0] dd, t;
        int n;
        dd = {d, d};
        n  = int'(s % 32);
        case (op)
            2'd0: return (s >= 32) ? 32'h0 : (d >> s);
            2'd1: return (s >= 32) ? 32'h0 : (d << s);
            2'd2: begin t = dd >> n; return t[31:0]; end
            default: begin t = dd << n; return t[63:32]; end
        endcase
    endfunction

    // Reference model: an op occupies positions 1..lat after its accept edge,
    // ACK at position 1, result valid at position lat.
    int          m_pos = 0, m_lat = 2;
    bit          m_prio = 0, m_id = 0;
    logic [31:0] m_res = '0;
    bit          e_ack0 = 0, e_ack1 = 0, e_vld = 0, e_id = 0;
    logic [31:0] e_res = '0;

    always @(posedge clk) begin
        logic [1:0]  g_op;
        logic [31:0] g_d, g_s;
        if (rst) begin
            m_pos = 0; m_prio = 0;
            e_ack0 = 0; e_ack1 = 0; e_vld = 0; e_id = 0; e_res = '0;
        end else if (m_pos == 0) begin
            e_vld = 0; e_ack0 = 0; e_ack1 = 0;
            if (req0 || req1) begin
                m_id   = (req0 && req1) ? m_prio : req1;
                m_prio = !m_id;
                g_op   = m_id ? op1 : op0;
                g_d    = m_id ? data1 : data0;
                g_s    = m_id ? shamt1 : shamt0;
                m_res  = ref_op(g_op, g_d, g_s);
                m_lat  = (g_op >= 2 && (g_s % 32) != 0) ? 3 : 2;
                m_pos  = 1;
                if (m_id) e_ack1 = 1; else e_ack0 = 1;
            end
        end else begin
            e_ack0 = 0; e_ack1 = 0;
            if (m_pos == m_lat) begin
                m_pos = 0; e_vld = 0;
            end else begin
                m_pos++;
                if (m_pos == m_lat) begin
                    e_vld = 1; e_res = m_res; e_id = m_id;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ack0", {31'b0, ack0}, {31'b0, e_ack0});
        chk("ack1", {31'b0, ack1}, {31'b0, e_ack1});
        chk("result_valid", {31'b0, result_valid}, {31'b0, e_vld});
        chk("result", result, e_res);
        chk("result_id", {31'b0, result_id}, {31'b0, e_id});
        if (m_pos == 0 || m_pos == m_lat) begin
            chk("sh_s_idle", sh_s, 32'h0);
            chk("sh_lnr_idle", {31'b0, sh_lnr}, 32'h0);
        end
    end

    task automatic run_op(input bit id, input logic [1:0] op, input logic [31:0] d, input logic [31:0] s,
                          input logic [31:0] exp_res, input int exp_lat, input string nm);
        bit found;
        int lat;
        if (id) begin op1 = op; data1 = d; shamt1 = s; req1 = 1'b1; end
        else    begin op0 = op; data0 = d; shamt0 = s; req0 = 1'b1; end
        @(negedge clk);
        chk({nm, "_ack_next_cycle"}, {31'b0, (id ? ack1 : ack0)}, 32'h1);
        if (id) req1 = 1'b0; else req0 = 1'b0;
        found = 0; lat = 0;
        for (int n = 1; n <= 8 && !found; n++) begin
            @(negedge clk);
            if (result_valid) begin found = 1; lat = n + 1; end
        end
        chk({nm, "_valid_seen"}, {31'b0, found}, 32'h1);
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_result"}, result, exp_res);
        chk({nm, "_id"}, {31'b0, result_id}, {31'b0, id});
        @(negedge clk);
    endtask

    task automatic wait_ack(output int who);
        who = -1;
        for (int n = 0; n < 12 && who < 0; n++) begin
            @(negedge clk);
            if (ack0) who = 0;
            else if (ack1) who = 1;
        end
        chk("ack_within_bound", {31'b0, (who >= 0)}, 32'h1);
    endtask

    initial begin
        int who;
        // 1: reset held with both requesting
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_ack", {30'b0, ack1, ack0}, 32'h0);
            chk("rst_valid", {31'b0, result_valid}, 32'h0);
            chk("rst_result", result, 32'h0);
            chk("rst_sh_d", sh_d, 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant_is_0", {30'b0, ack1, ack0}, 32'h1);
        req0 = 1'b0;
        wait_ack(who);
        chk("pending_req1_granted", who, 1);
        req1 = 1'b0;
        repeat (3) @(negedge clk);

        // 2-4: shifts and rotates
        run_op(0, 2'd0, 32'h8000_0000, 32'd4,  32'h0800_0000, 2, "srl4");
        run_op(1, 2'd1, 32'hFFFF_FFFF, 32'd40, 32'h0000_0000, 2, "sll40");
        run_op(1, 2'd1, 32'hFFFF_FFFF, 32'd31, 32'h8000_0000, 2, "sll31");
        run_op(0, 2'd3, 32'h8000_0001, 32'd1,  32'h0000_0003, 3, "rol1");
        run_op(1, 2'd2, 32'h8000_0001, 32'd1,  32'hC000_0000, 3, "ror1");
        run_op(0, 2'd2, 32'h8000_0001, 32'd32, 32'h8000_0001, 2, "ror32");

        // 5: contention from a fresh priority
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        op0 = 2'd1; data0 = 32'h1; shamt0 = 32'd3;
        op1 = 2'd0; data1 = 32'h100; shamt1 = 32'd4;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(who);
            chk("alternating_grant", who, i % 2);
            if (i == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end else begin
                if (who == 0) req0 = 1'b0; else req1 = 1'b0;
                @(negedge clk);
                if (who == 0) req0 = 1'b1; else req1 = 1'b1;
            end
        end
        repeat (4) @(negedge clk);

        // 6: reset during the second rotate pass
        op0 = 2'd3; data0 = 32'h8000_0001; shamt0 = 32'd1; req0 = 1'b1;
        @(negedge clk);
        chk("rol_abort_ack", {31'b0, ack0}, 32'h1);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_no_valid", {31'b0, result_valid}, 32'h0);
        chk("abort_result_cleared", result, 32'h0);
        op0 = 2'd0; data0 = 32'hF0; shamt0 = 32'd4;
        op1 = 2'd1; data1 = 32'h1;  shamt1 = 32'd1;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        chk("after_abort_prio0", {30'b0, ack1, ack0}, 32'h1);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("after_abort_valid", {31'b0, result_valid}, 32'h1);
        chk("after_abort_result", result, 32'h0000_000F);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
